// File: rtl/cam_pkg.sv
// ----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the CAM controller slice.
//   - command op encodings carried on cmd_op
//   - controller FSM state enum plus plain 2-bit state constants
//   - default sizing: NB_MEM entries and SIZE_ADDR index bits
// Optional feature macro used by this slice: CAM_CTRL_STATS_EN
// ----------------------------------------------------------------------------
package cam_pkg;

    // Default sizing; NB_MEM must never exceed 2**SIZE_ADDR.
    localparam int NB_MEM_DEF    = 14;
    localparam int SIZE_ADDR_DEF = 4;

    // Command encodings on cmd_op.
    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_FLUSH  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // Controller FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } cam_state_e;

    // Plain-vector aliases of the state enum, used by the state register so
    // the encoding stays visible in older tools and waveform viewers.
    localparam logic [1:0] ST_IDLE  = 2'(S_IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(S_ISSUE);
    localparam logic [1:0] ST_WAIT  = 2'(S_WAIT);
    localparam logic [1:0] ST_RESP  = 2'(S_RESP);

endpackage

// File: rtl/cam_ctrl_if.sv
// ----------------------------------------------------------------------------
// cam_ctrl_if
// Command / response handshake bundle of the CAM controller.
//   cmd_valid/cmd_ready : command handshake, cmd_op (2b) and cmd_data (8b)
//   rsp_valid/rsp_ready : response handshake, rsp_hit, rsp_idx (5b), rsp_err
// Modports: master = command issuer / response consumer, slave = controller.
// ----------------------------------------------------------------------------
interface cam_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic [4:0] rsp_idx;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_idx, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_idx, rsp_err
    );
endinterface

// File: rtl/cam_stats.sv
// ----------------------------------------------------------------------------
// cam_stats
// Saturating 16-bit hit/miss counters for completed lookups.
// Only instantiated when CAM_CTRL_STATS_EN is defined.
//   clk, rst_n   : clock, asynchronous active-low reset
//   lookup_done  : one-cycle strobe when a lookup result is resolved
//   lookup_hit   : result qualifier for lookup_done
//   clear        : synchronous clear (flush command)
//   stat_hits    : number of lookups that hit
//   stat_misses  : number of lookups that missed
// ----------------------------------------------------------------------------
module cam_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_done,
    input  logic        lookup_hit,
    input  logic        clear,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_misses
);
    logic [15:0] hits_q, hits_d;
    logic [15:0] misses_q, misses_d;

    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (clear) begin
            hits_d   = '0;
            misses_d = '0;
        end else if (lookup_done) begin
            // Counters stick at all-ones instead of wrapping.
            if (lookup_hit && hits_q != 16'hFFFF)
                hits_d = hits_q + 16'd1;
            if (!lookup_hit && misses_q != 16'hFFFF)
                misses_d = misses_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
endmodule

// File: rtl/cam_ctrl.sv
// ----------------------------------------------------------------------------
// cam_ctrl
// Front-end controller for an external CAM with a registered lookup result.
// Entries are appended in order; a valid mask hides stale CAM contents so
// that a flush is instant and never touches the CAM itself.
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (cam_ctrl_if)     : command / response handshakes (slave side)
//   cam_write, cam_enable : write strobe / lookup strobe, only in ISSUE
//   cam_addr, cam_data    : write address (bit 4 always 0), key
//   cam_out, cam_found    : registered lookup result from the CAM
//   fill                  : number of valid entries
//   stat_hits/stat_misses : lookup counters, only with CAM_CTRL_STATS_EN
// Optional feature macro: CAM_CTRL_STATS_EN
// ----------------------------------------------------------------------------
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int NB_MEM    = NB_MEM_DEF,
    parameter int SIZE_ADDR = SIZE_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cam_ctrl_if.slave            bus,
    output logic                 cam_write,
    output logic                 cam_enable,
    output logic [4:0]           cam_addr,
    output logic [7:0]           cam_data,
    input  logic [4:0]           cam_out,
    input  logic                 cam_found,
    output logic [SIZE_ADDR:0]   fill
`ifdef CAM_CTRL_STATS_EN
    ,
    output logic [15:0]          stat_hits,
    output logic [15:0]          stat_misses
`endif
);
    localparam int FILL_W  = SIZE_ADDR + 1;
    localparam int NB_SLOT = 1 << SIZE_ADDR;

    logic [1:0]           state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [7:0]           data_q, data_d;
    logic [SIZE_ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [NB_SLOT-1:0]   valid_q, valid_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_hit_q, rsp_hit_d;
    logic [4:0]           rsp_idx_q, rsp_idx_d;
    logic                 rsp_err_q, rsp_err_d;

    logic full;
    logic lookup_done;
    logic lookup_hit;
    logic stats_clear;

    assign full = (fill_q == FILL_W'(NB_MEM));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        valid_d     = valid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_err_d   = rsp_err_q;
        lookup_done = 1'b0;
        lookup_hit  = 1'b0;
        stats_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is high in IDLE, so cmd_valid alone means accept.
                if (bus.cmd_valid) begin
                    op_d    = bus.cmd_op;
                    data_d  = bus.cmd_data;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_hit_d   = 1'b0;
                rsp_idx_d   = '0;
                rsp_err_d   = 1'b0;
                case (op_q)
                    OP_WRITE: begin
                        if (!full) begin
                            valid_d[wr_ptr_q] = 1'b1;
                            wr_ptr_d          = wr_ptr_q + SIZE_ADDR'(1);
                            fill_d            = fill_q + FILL_W'(1);
                            rsp_idx_d         = 5'(wr_ptr_q);
                        end else begin
                            rsp_err_d = 1'b1;
                        end
                    end
                    OP_LOOKUP: begin
                        // The CAM result is registered: wait one cycle for it.
                        state_d     = ST_WAIT;
                        rsp_valid_d = 1'b0;
                    end
                    OP_FLUSH: begin
                        valid_d     = '0;
                        wr_ptr_d    = '0;
                        fill_d      = '0;
                        stats_clear = 1'b1;
                    end
                    default: begin
                        rsp_err_d = 1'b1;
                    end
                endcase
            end

            ST_WAIT: begin
                // A CAM match on an entry outside the valid mask is stale
                // (written before a flush) and must read as a miss.
                lookup_hit  = cam_found && valid_q[cam_out[SIZE_ADDR-1:0]];
                lookup_done = 1'b1;
                rsp_hit_d   = lookup_hit;
                rsp_idx_d   = lookup_hit ? cam_out : 5'd0;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LOOKUP;
            data_q      <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            valid_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            valid_q     <= valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // CAM strobes decode straight from the state register, so they are
    // single-cycle, mutually exclusive and drop as soon as reset asserts.
    assign cam_write  = (state_q == ST_ISSUE) && (op_q == OP_WRITE) && !full;
    assign cam_enable = (state_q == ST_ISSUE) && (op_q == OP_LOOKUP);
    assign cam_addr   = cam_write ? 5'(wr_ptr_q) : 5'd0;
    assign cam_data   = data_q;

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_err   = rsp_err_q;
    assign fill          = fill_q;

`ifdef CAM_CTRL_STATS_EN
    cam_stats u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_done (lookup_done),
        .lookup_hit  (lookup_hit),
        .clear       (stats_clear),
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
    );
`else
    // Strobes only feed the optional counters.
    logic unused_stats;
    assign unused_stats = lookup_done ^ lookup_hit ^ stats_clear;
`endif
endmodule

// File: tb/tb_cam_ctrl.sv
module tb_cam_ctrl;
    import cam_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cam_write, cam_enable;
    logic [4:0] cam_addr;
    logic [7:0] cam_data;
    logic [4:0] cam_out;
    logic       cam_found;
    logic [4:0] fill;
`ifdef CAM_CTRL_STATS_EN
    logic [15:0] stat_hits, stat_misses;
`endif

    cam_ctrl_if bus();

    cam_ctrl #(.NB_MEM(14), .SIZE_ADDR(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .cam_write  (cam_write),
        .cam_enable (cam_enable),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_out    (cam_out),
        .cam_found  (cam_found),
        .fill       (fill)
`ifdef CAM_CTRL_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CAM with a registered lookup result; contents survive
    // flush and reset of the controller, like a real external CAM.
    logic [7:0] cam_mem [32];
    logic [31:0] cam_present;
    initial cam_present = '0;
    initial begin
        cam_out   = '0;
        cam_found = 1'b0;
    end
    always @(posedge clk) begin
        if (cam_write) begin
            cam_mem[cam_addr]     <= cam_data;
            cam_present[cam_addr] <= 1'b1;
        end
        if (cam_enable) begin
            cam_found <= 1'b0;
            cam_out   <= 5'd0;
            for (int i = 31; i >= 0; i--) begin
                if (cam_present[i] && cam_mem[i] == cam_data) begin
                    cam_found <= 1'b1;
                    cam_out   <= 5'(i);
                end
            end
        end
    end

    // Strobe monitor, sampled mid-cycle.
    int         cw_cnt = 0, ce_cnt = 0, bad_cnt = 0;
    logic [4:0] last_cw_addr = '0;
    logic [7:0] last_cw_data = '0;
    always @(negedge clk) begin
        if (cam_write) begin
            cw_cnt       <= cw_cnt + 1;
            last_cw_addr <= cam_addr;
            last_cw_data <= cam_data;
        end
        if (cam_enable) ce_cnt <= ce_cnt + 1;
        if ((cam_write && cam_enable) || cam_addr[4]) bad_cnt <= bad_cnt + 1;
    end

    int tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction; latency counts clock edges from the accept edge
    // (inclusive) until rsp_valid is seen high.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data,
                          output logic hit, output logic [4:0] idx, output logic err,
                          output int lat, output int cw, output int ce, output bit to);
        int cw0, ce0, n;
        cw0 = cw_cnt;
        ce0 = ce_cnt;
        to  = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) to = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid) begin
            if (lat >= 20) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        hit = bus.rsp_hit;
        idx = bus.rsp_idx;
        err = bus.rsp_err;
        @(posedge clk);
        #1;
        cw = cw_cnt - cw0;
        ce = ce_cnt - ce0;
        $display("[TB] op=%0d data=%02h -> hit=%0d idx=%0d err=%0d lat=%0d fill=%0d",
                 op, data, hit, idx, err, lat, fill);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic       hit;
        logic [4:0] idx;
        logic       err;
        int         lat;
        logic [4:0] fill;
        int         cw;
        int         ce;
    } vec_t;

    function automatic vec_t mk(logic [1:0] op, logic [7:0] data, logic hit, logic [4:0] idx,
                                logic err, int lat, logic [4:0] fl, int cw, int ce);
        vec_t v;
        v.op = op; v.data = data; v.hit = hit; v.idx = idx; v.err = err;
        v.lat = lat; v.fill = fl; v.cw = cw; v.ce = ce;
        return v;
    endfunction

    vec_t vecs [13];

    initial begin
        logic       hit, err;
        logic [4:0] idx;
        int         lat, cw, ce, n;
        bit         to;
        logic [4:0] st_idx;
        logic       st_hit, st_err;

        vecs[0]  = mk(OP_WRITE,  8'h11, 1'b0, 5'd0, 1'b0, 2, 5'd1, 1, 0);
        vecs[1]  = mk(OP_WRITE,  8'h22, 1'b0, 5'd1, 1'b0, 2, 5'd2, 1, 0);
        vecs[2]  = mk(OP_WRITE,  8'h33, 1'b0, 5'd2, 1'b0, 2, 5'd3, 1, 0);
        vecs[3]  = mk(OP_LOOKUP, 8'h22, 1'b1, 5'd1, 1'b0, 3, 5'd3, 0, 1);
        vecs[4]  = mk(OP_LOOKUP, 8'h44, 1'b0, 5'd0, 1'b0, 3, 5'd3, 0, 1);
        vecs[5]  = mk(OP_LOOKUP, 8'h11, 1'b1, 5'd0, 1'b0, 3, 5'd3, 0, 1);
        vecs[6]  = mk(OP_RSVD,   8'h00, 1'b0, 5'd0, 1'b1, 2, 5'd3, 0, 0);
        vecs[7]  = mk(OP_WRITE,  8'h5A, 1'b0, 5'd3, 1'b0, 2, 5'd4, 1, 0);
        vecs[8]  = mk(OP_FLUSH,  8'h00, 1'b0, 5'd0, 1'b0, 2, 5'd0, 0, 0);
        vecs[9]  = mk(OP_LOOKUP, 8'h5A, 1'b0, 5'd0, 1'b0, 3, 5'd0, 0, 1);
        vecs[10] = mk(OP_WRITE,  8'h77, 1'b0, 5'd0, 1'b0, 2, 5'd1, 1, 0);
        vecs[11] = mk(OP_LOOKUP, 8'h77, 1'b1, 5'd0, 1'b0, 3, 5'd1, 0, 1);
        vecs[12] = mk(OP_LOOKUP, 8'h22, 1'b0, 5'd0, 1'b0, 3, 5'd1, 0, 1);

        bus.cmd_op   = OP_LOOKUP;
        bus.cmd_data = 8'h00;
        do_reset();

        // Reset values
        #1;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_fields", {bus.rsp_hit, bus.rsp_idx, bus.rsp_err}, 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_cam_strobes", {cam_write, cam_enable}, 32'd0);

        // First write after reset
        do_cmd(OP_WRITE, 8'hA5, hit, idx, err, lat, cw, ce, to);
        check("w1_timeout", 32'(to), 32'd0);
        check("w1_idx", 32'(idx), 32'd0);
        check("w1_err", 32'(err), 32'd0);
        check("w1_lat", 32'(lat), 32'd2);
        check("w1_cw_pulses", 32'(cw), 32'd1);
        check("w1_cam_addr", 32'(last_cw_addr), 32'd0);
        check("w1_cam_data", 32'(last_cw_data), 32'hA5);
        check("w1_fill", 32'(fill), 32'd1);

        // Table-driven sequence from a fresh reset
        do_reset();
        for (int i = 0; i < 13; i++) begin
            do_cmd(vecs[i].op, vecs[i].data, hit, idx, err, lat, cw, ce, to);
            check($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
            check($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].hit));
            check($sformatf("v%0d_idx", i), 32'(idx), 32'(vecs[i].idx));
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_fill", i), 32'(fill), 32'(vecs[i].fill));
            check($sformatf("v%0d_cw", i), cw, vecs[i].cw);
            check($sformatf("v%0d_ce", i), ce, vecs[i].ce);
        end
`ifdef CAM_CTRL_STATS_EN
        check("stat_hits", 32'(stat_hits), 32'd1);
        check("stat_misses", 32'(stat_misses), 32'd2);
`endif

        // Fill to capacity, then overflow
        do_reset();
        for (int i = 0; i < 14; i++) begin
            do_cmd(OP_WRITE, 8'(8'h80 + i), hit, idx, err, lat, cw, ce, to);
            check($sformatf("full_w%0d_idx", i), 32'(idx), 32'(i));
            check($sformatf("full_w%0d_err", i), 32'(err), 32'd0);
        end
        check("full_fill14", 32'(fill), 32'd14);
        do_cmd(OP_WRITE, 8'hEE, hit, idx, err, lat, cw, ce, to);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_idx", 32'(idx), 32'd0);
        check("ovf_cw", cw, 0);
        check("ovf_lat", lat, 2);
        check("ovf_fill", 32'(fill), 32'd14);
        do_cmd(OP_LOOKUP, 8'h8D, hit, idx, err, lat, cw, ce, to);
        check("last_entry_hit", 32'(hit), 32'd1);
        check("last_entry_idx", 32'(idx), 32'd13);

        // Response back-pressure: fields stable, no new command accepted
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOOKUP;
        bus.cmd_data  = 8'h85;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check("stall_timeout", 32'(n < 10), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_WRITE;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall%0d_hit", k), 32'(bus.rsp_hit), 32'd1);
            check($sformatf("stall%0d_idx", k), 32'(bus.rsp_idx), 32'd5);
            check($sformatf("stall%0d_err", k), 32'(bus.rsp_err), 32'd0);
            check($sformatf("stall%0d_cmd_ready", k), 32'(bus.cmd_ready), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_valid", 32'(bus.rsp_valid), 32'd0);
        check("stall_release_ready", 32'(bus.cmd_ready), 32'd1);
        check("stall_fill", 32'(fill), 32'd14);
        $display("[TB] stall: lookup 85 held 5 cycles, fill=%0d", fill);

        // Reset while waiting on a lookup result
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOOKUP;
        bus.cmd_data  = 8'h80;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rstw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rstw_rsp_fields", {bus.rsp_hit, bus.rsp_idx, bus.rsp_err}, 32'd0);
        check("rstw_cam_strobes", {cam_write, cam_enable}, 32'd0);
        check("rstw_fill", 32'(fill), 32'd0);
        check("rstw_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) n++;
        end
        check("rstw_no_response", n, 0);
        $display("[TB] reset during WAIT: spurious responses=%0d", n);

        // Reset while a write is in ISSUE: the write is not counted
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_WRITE;
        bus.cmd_data  = 8'h99;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rsti_fill", 32'(fill), 32'd0);
        check("rsti_cam_write", 32'(cam_write), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(OP_WRITE, 8'h42, hit, idx, err, lat, cw, ce, to);
        check("rsti_next_idx", 32'(idx), 32'd0);
        check("rsti_next_fill", 32'(fill), 32'd1);

        check("strobe_rules", bad_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
